// File: rtl/time_set_controller_pkg.sv
// Shared types and limits for the time-set controller: state encoding
// (which is also the display field code), field widths and wrap limits.
package time_set_controller_pkg;

  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 6;
  localparam int IDLE_W = 6;

  localparam logic [HOUR_W-1:0] HOUR_MAX   = 5'd23;
  localparam logic [MIN_W-1:0]  MINSEC_MAX = 6'd59;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } state_e;

endpackage

// File: rtl/time_set_controller_if.sv
// Button, tick, running-time and edited-time bundle between the controller
// (slave) and whatever drives the buttons and timekeeper (master).
interface time_set_controller_if;
  import time_set_controller_pkg::*;

  logic              btn_mode;
  logic              btn_up;
  logic              btn_down;
  logic              sec_tick;
  logic [HOUR_W-1:0] cur_hour;
  logic [MIN_W-1:0]  cur_min;
  logic [SEC_W-1:0]  cur_sec;
  logic [HOUR_W-1:0] set_hour;
  logic [MIN_W-1:0]  set_min;
  logic [SEC_W-1:0]  set_sec;
  logic              load;
  logic              editing;
  logic [1:0]        field;

  modport master (
    output btn_mode, btn_up, btn_down, sec_tick, cur_hour, cur_min, cur_sec,
    input  set_hour, set_min, set_sec, load, editing, field
  );

  modport slave (
    input  btn_mode, btn_up, btn_down, sec_tick, cur_hour, cur_min, cur_sec,
    output set_hour, set_min, set_sec, load, editing, field
  );

endinterface

// File: rtl/time_set_controller_wrap_counter_step.sv
// One +1/-1 step of a modular counter over 0..max; up and down together,
// or neither, leave the value unchanged.
module wrap_counter_step #(
  parameter int W = 6
) (
  input  logic [W-1:0] value,
  input  logic [W-1:0] max,
  input  logic         up,
  input  logic         down,
  output logic [W-1:0] result
);

  always_comb begin
    result = value;
    if (up && !down)
      result = (value == max) ? '0 : value + W'(1);
    else if (down && !up)
      result = (value == '0) ? max : value - W'(1);
  end

endmodule

// File: rtl/time_set_controller.sv
// Mode/up/down time-setting FSM with registered edit fields and a one-cycle
// load strobe. Define TIME_SET_TIMEOUT_EN to abandon idle edits after TIMEOUT_SEC.
module time_set_controller
  import time_set_controller_pkg::*;
#(
  parameter int TIMEOUT_SEC = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  time_set_controller_if.slave bus
);

  if (TIMEOUT_SEC < 1 || TIMEOUT_SEC > 63) begin : g_bad_timeout
    $error("TIMEOUT_SEC must be in 1..63");
  end

  state_e            state_q, state_d;
  logic [HOUR_W-1:0] hour_q, hour_d, hour_step;
  logic [MIN_W-1:0]  min_q, min_d, min_step;
  logic [SEC_W-1:0]  sec_q, sec_d, sec_step;
  logic              load_q, load_d;
  logic              editing_q, editing_d;
  logic [1:0]        field_q, field_d;
  logic              step_up, step_dn, timed_out;

  // mode outranks up/down; up with down cancels out
  assign step_up = bus.btn_up & ~bus.btn_down & ~bus.btn_mode;
  assign step_dn = bus.btn_down & ~bus.btn_up & ~bus.btn_mode;

  wrap_counter_step #(.W(HOUR_W)) u_hour (
    .value(hour_q), .max(HOUR_MAX),
    .up(step_up && state_q == SET_HOUR), .down(step_dn && state_q == SET_HOUR),
    .result(hour_step));
  wrap_counter_step #(.W(MIN_W)) u_min (
    .value(min_q), .max(MINSEC_MAX),
    .up(step_up && state_q == SET_MIN), .down(step_dn && state_q == SET_MIN),
    .result(min_step));
  wrap_counter_step #(.W(SEC_W)) u_sec (
    .value(sec_q), .max(MINSEC_MAX),
    .up(step_up && state_q == SET_SEC), .down(step_dn && state_q == SET_SEC),
    .result(sec_step));

`ifdef TIME_SET_TIMEOUT_EN
  logic [IDLE_W-1:0] idle_q, idle_d;
  assign timed_out = (state_q != RUN) && (idle_q >= IDLE_W'(TIMEOUT_SEC));

  // any accepted pulse restarts the count, even alongside a tick
  always_comb begin
    idle_d = idle_q;
    if (state_q == RUN || timed_out || bus.btn_mode || step_up || step_dn)
      idle_d = '0;
    else if (bus.sec_tick)
      idle_d = idle_q + IDLE_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) idle_q <= '0;
    else        idle_q <= idle_d;
  end
`else
  assign timed_out = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;
    load_d  = 1'b0;
    unique case (state_q)
      RUN: begin
        if (bus.btn_mode) begin
          state_d = SET_HOUR;
          hour_d  = bus.cur_hour;
          min_d   = bus.cur_min;
          sec_d   = bus.cur_sec;
        end
      end
      default: begin
        if (timed_out) begin
          state_d = RUN;
        end else if (bus.btn_mode) begin
          unique case (state_q)
            SET_HOUR: state_d = SET_MIN;
            SET_MIN:  state_d = SET_SEC;
            default: begin
              state_d = RUN;
              load_d  = 1'b1;
            end
          endcase
        end else begin
          hour_d = hour_step;
          min_d  = min_step;
          sec_d  = sec_step;
        end
      end
    endcase
    editing_d = (state_d != RUN);
    field_d   = state_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= RUN;
      hour_q    <= '0;
      min_q     <= '0;
      sec_q     <= '0;
      load_q    <= 1'b0;
      editing_q <= 1'b0;
      field_q   <= 2'd0;
    end else begin
      state_q   <= state_d;
      hour_q    <= hour_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      load_q    <= load_d;
      editing_q <= editing_d;
      field_q   <= field_d;
    end
  end

  assign bus.set_hour = hour_q;
  assign bus.set_min  = min_q;
  assign bus.set_sec  = sec_q;
  assign bus.load     = load_q;
  assign bus.editing  = editing_q;
  assign bus.field    = field_q;

endmodule

// File: tb/tb_time_set_controller.sv
// Directed bench for time_set_controller: a clock-time model checked every
// cycle plus literal checkpoints for the named scenarios.
module tb_time_set_controller;

  localparam int TO = 3;
`ifdef TIME_SET_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  time_set_controller_if bus ();

  time_set_controller #(.TIMEOUT_SEC(TO)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: which field is being edited (0 = none), edited time, idle seconds.
  int m_f = 0, m_h = 0, m_m = 0, m_s = 0, m_idle = 0;
  bit m_ld = 1'b0;

  always @(posedge clk) begin
    m_ld = 1'b0;
    if (!reset) begin
      m_f = 0; m_h = 0; m_m = 0; m_s = 0; m_idle = 0;
    end else if (m_f == 0) begin
      if (bus.btn_mode) begin
        m_h = bus.cur_hour; m_m = bus.cur_min; m_s = bus.cur_sec;
        m_f = 1; m_idle = 0;
      end
    end else if (TO_EN && m_idle >= TO) begin
      m_f = 0; m_idle = 0;
    end else if (bus.btn_mode) begin
      m_idle = 0;
      if (m_f == 3) begin m_f = 0; m_ld = 1'b1; end
      else m_f = m_f + 1;
    end else if (bus.btn_up != bus.btn_down) begin
      m_idle = 0;
      case (m_f)
        1: m_h = bus.btn_up ? (m_h + 1) % 24 : (m_h + 23) % 24;
        2: m_m = bus.btn_up ? (m_m + 1) % 60 : (m_m + 59) % 60;
        default: m_s = bus.btn_up ? (m_s + 1) % 60 : (m_s + 59) % 60;
      endcase
    end else if (TO_EN && bus.sec_tick) begin
      m_idle = m_idle + 1;
    end
    #1;
    check("model.field",   bus.field,    m_f);
    check("model.editing", bus.editing,  m_f != 0);
    check("model.load",    bus.load,     m_ld);
    check("model.hour",    bus.set_hour, m_h);
    check("model.min",     bus.set_min,  m_m);
    check("model.sec",     bus.set_sec,  m_s);
  end

  // Drive one cycle of inputs starting at a negedge; ends at the next negedge.
  task automatic step(input bit md, input bit up, input bit dn, input bit tk);
    bus.btn_mode = md; bus.btn_up = up; bus.btn_down = dn; bus.sec_tick = tk;
    @(negedge clk);
    bus.btn_mode = 0; bus.btn_up = 0; bus.btn_down = 0; bus.sec_tick = 0;
  endtask

  task automatic set_cur(input int h, input int m, input int s);
    bus.cur_hour = 5'(h); bus.cur_min = 6'(m); bus.cur_sec = 6'(s);
  endtask

  task automatic check_time(input string name, input int h, input int m, input int s);
    check({name, ".hour"}, bus.set_hour, h);
    check({name, ".min"},  bus.set_min,  m);
    check({name, ".sec"},  bus.set_sec,  s);
  endtask

  initial begin
    reset = 1'b0;
    bus.btn_mode = 0; bus.btn_up = 0; bus.btn_down = 0; bus.sec_tick = 0;
    set_cur(0, 0, 0);
    @(negedge clk); @(negedge clk);
    check("rst.field", bus.field, 0);
    check("rst.load", bus.load, 0);
    check("rst.editing", bus.editing, 0);
    check_time("rst", 0, 0, 0);
    reset = 1'b1;

    // Enter edit from 12:34:56, bump hour, walk fields, commit.
    set_cur(12, 34, 56);
    step(0, 1, 0, 0);                       // up ignored in RUN
    check_time("run_up", 0, 0, 0);
    step(1, 0, 0, 0);
    check("enter.field", bus.field, 1);
    check("enter.editing", bus.editing, 1);
    check_time("enter", 12, 34, 56);
    step(0, 1, 0, 0);
    check("bump.hour", bus.set_hour, 13);
    step(1, 0, 0, 0);
    check("adv.field", bus.field, 2);
    step(1, 0, 0, 0);
    check("adv2.field", bus.field, 3);
    step(1, 0, 0, 0);
    check("commit.load", bus.load, 1);
    check("commit.field", bus.field, 0);
    check_time("commit", 13, 34, 56);
    step(0, 0, 0, 0);
    check("post.load", bus.load, 0);

    // Wrap boundaries.
    set_cur(23, 0, 0);
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    check("wrap.h_up", bus.set_hour, 0);
    step(0, 0, 1, 0);
    check("wrap.h_dn", bus.set_hour, 23);
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    check("wrap.m_dn", bus.set_min, 59);
    step(0, 1, 0, 0);
    check("wrap.m_up", bus.set_min, 0);
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    check("wrap.s_dn", bus.set_sec, 59);
    step(1, 0, 0, 0);
    check("wrap.commit_load", bus.load, 1);
    check_time("wrap.commit", 23, 0, 59);

    // Simultaneous pulses.
    set_cur(5, 10, 20);
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    check("simul.field", bus.field, 2);
    check("simul.hour", bus.set_hour, 5);
    step(0, 1, 1, 0);
    check("updn.min", bus.set_min, 10);

    // Reset in SET_SEC, with a mode pulse on the same edge.
    step(1, 0, 0, 0);
    check("pre_rst.field", bus.field, 3);
    reset = 1'b0;
    step(1, 0, 0, 0);
    reset = 1'b1;
    check("mid_rst.field", bus.field, 0);
    check("mid_rst.load", bus.load, 0);
    check_time("mid_rst", 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 0);
      check("post_rst.load", bus.load, 0);
    end

    // Idle timeout with a restart between ticks 2 and 3.
    set_cur(7, 8, 9);
    step(1, 0, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    check("to.restart_field", bus.field, 1);
    check("to.restart_hour", bus.set_hour, 8);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    check("to.field", bus.field, TO_EN ? 0 : 1);
    check("to.load", bus.load, 0);
    if (bus.field != 0) begin
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      check("noto.commit_load", bus.load, 1);
    end
    step(0, 0, 0, 0);
    check("end.load", bus.load, 0);
    check("end.field", bus.field, 0);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
